// File: rtl/level_map.sv
// Multi-level tile map: copies one of LEVELS constant patterns into a writable
// working map (one row per cycle), supports per-tile clears, queries and pixel lookup.
module level_map #(
   parameter int COLS        = 10,
   parameter int ROWS        = 11,
   parameter int LEVELS      = 4,
   parameter int TILE_W_LOG2 = 6,
   parameter int TILE_H_LOG2 = 5,
   parameter logic [LEVELS*ROWS*COLS-1:0] INIT = {{((LEVELS-1)*ROWS*COLS){1'b0}},
      10'h3FF, 10'h3FF, 10'h3FF, 10'h301, 10'h183, 10'h0C6,
      10'h06C, 10'h038, 10'h3FF, 10'h3FF, 10'h3FF}
) (
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic                              load_req,
   input  logic [$clog2(LEVELS)-1:0]         level_sel,
   output logic                              busy,
   input  logic                              clr_valid,
   input  logic [$clog2(ROWS)-1:0]           clr_row,
   input  logic [$clog2(COLS)-1:0]           clr_col,
   input  logic [$clog2(ROWS)-1:0]           q_row,
   input  logic [$clog2(COLS)-1:0]           q_col,
   output logic                              q_hit,
   input  logic [9:0]                        DrawX,
   input  logic [9:0]                        DrawY,
   output logic                              tile_on,
   output logic [$clog2(ROWS*COLS+1)-1:0]    tiles_left,
   output logic                              level_clear,
   output logic                              dbg_state
);
   localparam int LW = $clog2(LEVELS);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int TW = $clog2(ROWS*COLS+1);
   localparam logic [CW-1:0] CMAX = CW'(COLS-1);
   localparam logic [RW-1:0] RMAX = RW'(ROWS-1);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [COLS-1:0]   map_q [ROWS];
   logic [COLS-1:0]   map_d [ROWS];
   logic [TW-1:0]     tiles_q, tiles_d;
   logic [RW-1:0]     cnt_q, cnt_d;
   logic [LW-1:0]     sel_q, sel_d;
   logic              loaded_q, loaded_d;
   logic              q_hit_q, q_hit_d;
   logic              tile_on_q, tile_on_d;
   logic [COLS-1:0]   rom_row;
   int                rom_base;
   logic [9:0]        px_col, px_row;

   function automatic logic [TW-1:0] popcount(input logic [COLS-1:0] v);
      logic [TW-1:0] n;
      n = '0;
      for (int i = 0; i < COLS; i++) n = n + TW'(v[i]);
      return n;
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         for (int r = 0; r < ROWS; r++) map_q[r] <= '0;
         tiles_q   <= '0;
         cnt_q     <= '0;
         sel_q     <= '0;
         loaded_q  <= 1'b0;
         q_hit_q   <= 1'b0;
         tile_on_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         for (int r = 0; r < ROWS; r++) map_q[r] <= map_d[r];
         tiles_q   <= tiles_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         loaded_q  <= loaded_d;
         q_hit_q   <= q_hit_d;
         tile_on_q <= tile_on_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_req) state_d = LOAD;
         LOAD:    if (cnt_q == RMAX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rom_base = (int'(sel_q) * ROWS + int'(cnt_q)) * COLS;
      rom_row  = INIT[rom_base +: COLS];
   end

   // Load and clear share one next-state block so load_req can pre-empt a same-cycle clear.
   always_comb begin
      for (int r = 0; r < ROWS; r++) map_d[r] = map_q[r];
      tiles_d  = tiles_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      loaded_d = loaded_q;
      if (state_q == IDLE) begin
         if (load_req) begin
            sel_d   = (int'(level_sel) < LEVELS) ? level_sel : '0;
            cnt_d   = '0;
            tiles_d = '0;
         end else if (clr_valid && clr_row <= RMAX && clr_col <= CMAX &&
                      map_q[clr_row][CMAX - clr_col]) begin
            map_d[clr_row][CMAX - clr_col] = 1'b0;
            tiles_d = tiles_q - 1'b1;
         end
      end else begin
         map_d[cnt_q] = rom_row;
         tiles_d      = tiles_q + popcount(rom_row);
         if (cnt_q == RMAX) begin
            loaded_d = 1'b1;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Lookups read map_q, i.e. the map before any clear accepted on the same edge.
   always_comb begin
      px_col  = DrawX >> TILE_W_LOG2;
      px_row  = DrawY >> TILE_H_LOG2;
      q_hit_d = 1'b0;
      if (q_row <= RMAX && q_col <= CMAX) q_hit_d = map_q[q_row][CMAX - q_col];
      tile_on_d = 1'b0;
      if (int'(px_col) < COLS && int'(px_row) < ROWS && state_q == IDLE)
         tile_on_d = map_q[px_row[RW-1:0]][CMAX - px_col[CW-1:0]];
   end

   always_comb begin
      busy        = (state_q == LOAD);
      level_clear = loaded_q && (state_q != LOAD) && (tiles_q == '0);
      tiles_left  = tiles_q;
      q_hit       = q_hit_q;
      tile_on     = tile_on_q;
      dbg_state   = state_q;
   end
endmodule

// File: tb/tb_level_map.sv
// Directed + random checks of level_map against a tile-grid reference model.
module tb_level_map;
   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       load_req = 1'b0;
   logic [1:0] level_sel = '0;
   logic       clr_valid = 1'b0;
   logic [3:0] clr_row = '0, clr_col = '0;
   logic [3:0] q_row = '0, q_col = '0;
   logic [9:0] DrawX = '0, DrawY = '0;
   logic       busy, q_hit, tile_on, level_clear, dbg_state;
   logic [6:0] tiles_left;
   logic       busy2, q_hit2, tile_on2, level_clear2, dbg_state2;
   logic [6:0] tiles_left2;

   int n_checks = 0;
   int n_fail   = 0;

   bit [9:0] lvl0 [11] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h038, 10'h06C, 10'h0C6,
                           10'h183, 10'h301, 10'h3FF, 10'h3FF, 10'h3FF};
   bit [9:0] mrow [11];
   bit       mloaded;

   level_map dut (
      .Clk(Clk), .Reset(Reset), .load_req(load_req), .level_sel(level_sel), .busy(busy),
      .clr_valid(clr_valid), .clr_row(clr_row), .clr_col(clr_col),
      .q_row(q_row), .q_col(q_col), .q_hit(q_hit), .DrawX(DrawX), .DrawY(DrawY),
      .tile_on(tile_on), .tiles_left(tiles_left), .level_clear(level_clear),
      .dbg_state(dbg_state));

   // Three-level variant: a 2-bit level_sel of 3 is out of range and must load level 0.
   level_map #(.LEVELS(3)) dut2 (
      .Clk(Clk), .Reset(Reset), .load_req(load_req), .level_sel(level_sel), .busy(busy2),
      .clr_valid(clr_valid), .clr_row(clr_row), .clr_col(clr_col),
      .q_row(q_row), .q_col(q_col), .q_hit(q_hit2), .DrawX(DrawX), .DrawY(DrawY),
      .tile_on(tile_on2), .tiles_left(tiles_left2), .level_clear(level_clear2),
      .dbg_state(dbg_state2));

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic void m_reset();
      for (int r = 0; r < 11; r++) mrow[r] = '0;
      mloaded = 1'b0;
   endfunction

   function automatic void m_load(input int lvl, input int nlevels);
      int l;
      l = (lvl < nlevels) ? lvl : 0;
      for (int r = 0; r < 11; r++) mrow[r] = (l == 0) ? lvl0[r] : 10'h000;
      mloaded = 1'b1;
   endfunction

   function automatic int m_tiles();
      int n;
      n = 0;
      for (int r = 0; r < 11; r++) n += $countones(mrow[r]);
      return n;
   endfunction

   function automatic bit m_bit(input int r, input int c);
      if (r < 11 && c < 10) return mrow[r][9-c];
      return 1'b0;
   endfunction

   function automatic void m_clear(input int r, input int c);
      if (r < 11 && c < 10) mrow[r][9-c] = 1'b0;
   endfunction

   // Issue a load; optionally a same-cycle clear and a mid-load load/clear that must be ignored.
   task automatic do_load(input int sel, input bit clr_too, input bit poke);
      int n;
      level_sel = 2'(sel);
      load_req  = 1'b1;
      clr_valid = clr_too;
      clr_row   = 4'd0;
      clr_col   = 4'd1;
      step();
      load_req  = 1'b0;
      clr_valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         if (n > 0) chk("tile_on_during_load", tile_on, 1'b0);
         if (poke && n == 3) begin
            load_req = 1'b1; level_sel = 2'd2;
            clr_valid = 1'b1; clr_row = 4'd0; clr_col = 4'd0;
         end
         n++;
         step();
         load_req  = 1'b0;
         clr_valid = 1'b0;
      end
      chk("busy_cycles", n, 11);
      m_load(sel, 4);
      chk("tiles_after_load", tiles_left, m_tiles());
      chk("level_clear_after_load", level_clear, (m_tiles() == 0));
   endtask

   task automatic query(input int r, input int c);
      q_row = 4'(r);
      q_col = 4'(c);
      step();
      chk("q_hit", q_hit, m_bit(r, c));
   endtask

   task automatic clear(input int r, input int c);
      clr_valid = 1'b1;
      clr_row   = 4'(r);
      clr_col   = 4'(c);
      step();
      clr_valid = 1'b0;
      m_clear(r, c);
      chk("tiles_after_clear", tiles_left, m_tiles());
   endtask

   task automatic pixel(input int x, input int y);
      DrawX = 10'(x);
      DrawY = 10'(y);
      step();
      chk("tile_on", tile_on, m_bit(y >> 5, x >> 6));
   endtask

   initial begin
      int qr, qc, cr, cc, x, y;
      bit cv, exp_q, exp_t;
      m_reset();
      repeat (3) step();
      Reset = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_q_hit", q_hit, 1'b0);
      chk("rst_tile_on", tile_on, 1'b0);
      chk("rst_level_clear", level_clear, 1'b0);
      chk("rst_tiles_left", tiles_left, 0);
      chk("rst_state", dbg_state, 1'b0);

      do_load(0, 1'b0, 1'b0);
      chk("level0_count", tiles_left, 78);
      query(3, 4);
      query(3, 0);
      query(11, 2);
      clear(0, 0);
      clear(0, 0);
      chk("double_clear", tiles_left, 77);
      clear(11, 0);
      clear(2, 12);
      pixel(64, 96);
      pixel(256, 96);
      pixel(256, 352);
      pixel(700, 0);

      // Random clears with same-cycle query and pixel lookups that must see the pre-clear map.
      for (int i = 0; i < 80; i++) begin
         qr = $urandom_range(0, 15); qc = $urandom_range(0, 15);
         cr = $urandom_range(0, 12); cc = $urandom_range(0, 11);
         x  = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
         cv = 1'($urandom_range(0, 1));
         exp_q = m_bit(qr, qc);
         exp_t = m_bit(y >> 5, x >> 6);
         q_row = 4'(qr); q_col = 4'(qc);
         clr_row = 4'(cr); clr_col = 4'(cc); clr_valid = cv;
         DrawX = 10'(x); DrawY = 10'(y);
         step();
         clr_valid = 1'b0;
         if (cv) m_clear(cr, cc);
         chk("rand_q_hit", q_hit, exp_q);
         chk("rand_tile_on", tile_on, exp_t);
         chk("rand_tiles_left", tiles_left, m_tiles());
         chk("rand_level_clear", level_clear, 1'b0);
      end

      do_load(2, 1'b0, 1'b0);
      chk("level2_empty", tiles_left, 0);
      chk("level2_clear", level_clear, 1'b1);
      query(0, 0);

      do_load(3, 1'b0, 1'b0);
      chk("dut2_busy", busy2, 1'b0);
      chk("dut2_sel_oor_count", tiles_left2, 78);
      chk("dut2_level_clear", level_clear2, 1'b0);
      chk("dut2_state", dbg_state2, 1'b0);
      q_row = 4'd3; q_col = 4'd4;
      DrawX = 10'd256; DrawY = 10'd96;
      step();
      chk("dut2_q_hit", q_hit2, 1'b1);
      chk("dut2_tile_on", tile_on2, 1'b1);

      do_load(0, 1'b1, 1'b0);
      chk("load_beats_clear", tiles_left, 78);
      query(0, 1);
      do_load(0, 1'b0, 1'b1);
      chk("load_ignores_requests", tiles_left, 78);
      query(0, 0);

      level_sel = 2'd0;
      load_req  = 1'b1;
      step();
      load_req = 1'b0;
      repeat (5) step();
      chk("midload_busy", busy, 1'b1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      m_reset();
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_level_clear", level_clear, 1'b0);
      chk("midrst_tiles", tiles_left, 0);
      chk("midrst_tile_on", tile_on, 1'b0);
      chk("midrst_q_hit", q_hit, 1'b0);
      query(0, 0);
      pixel(0, 0);
      step();
      chk("midrst_idle_stays", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
